wb_buffer: RTL and testbench

WB_BUFFER -- requirements
Module: wb_buffer

---
 rtl/wb_buffer.sv | 106 ++++++++++
 tb/tb_wb_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// Writeback buffer: DEPTH-entry FIFO between MEM and the register-file write port, one-cycle latency.
// Optional WB_STALL_CNT_EN adds a saturating stall_cycles counter of offered-but-refused cycles.
module wb_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wb_en,
  input  logic        in_mem_r_en,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_data,
  input  logic        rf_stall,
  output logic        WB_Write_Enable,
  output logic [4:0]  WB_Dest,
  output logic [31:0] WB_Data,
`ifdef WB_STALL_CNT_EN
  output logic [31:0] pending,
  output logic [31:0] stall_cycles
`else
  output logic [31:0] pending
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          store;
  logic          retire;
  logic [PW-1:0] age;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count != FULL);
  assign accept   = in_valid && in_ready;
  // Writes to r0 or non-writing instructions are consumed but never occupy a slot.
  assign store    = accept && in_wb_en && (in_dest != 5'd0);
  assign retire   = (count != '0) && !rf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (store) begin
        dest_q[wr_ptr] <= in_dest;
        data_q[wr_ptr] <= in_mem_r_en ? in_mem_data : in_alu_result;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (retire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({store, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign WB_Write_Enable = retire;
  assign WB_Dest         = (count != '0) ? dest_q[rd_ptr] : 5'd0;
  assign WB_Data         = (count != '0) ? data_q[rd_ptr] : 32'd0;

  // An entry is live when its distance from the head is below count.
  always_comb begin
    pending = '0;
    age     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PW'(i) - rd_ptr;
      if ({1'b0, age} < count) begin
        pending[dest_q[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Scoreboard bench for wb_buffer: queue-based reference model, directed scenarios then random traffic.
module tb_wb_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic        in_mem_r_en;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic        rf_stall;
  logic        WB_Write_Enable;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Data;
  logic [31:0] pending;
`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_wb_en        (in_wb_en),
    .in_mem_r_en     (in_mem_r_en),
    .in_dest         (in_dest),
    .in_alu_result   (in_alu_result),
    .in_mem_data     (in_mem_data),
    .rf_stall        (rf_stall),
    .WB_Write_Enable (WB_Write_Enable),
    .WB_Dest         (WB_Dest),
    .WB_Data         (WB_Data),
`ifdef WB_STALL_CNT_EN
    .pending         (pending),
    .stall_cycles    (stall_cycles)
`else
    .pending         (pending)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        model_buf[$];  // what the buffer should hold right now
  ent_t        exp_q[$];      // writes the register file should still see, in order
  logic [31:0] model_stall = 32'd0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (model_buf[i]) p = p | (32'd1 << model_buf[i].dest);
    return p;
  endfunction

  // Reference model: acceptance uses occupancy before the edge, retire pops the oldest.
  always @(posedge clk) begin
    int   n;
    ent_t e;
    if (!rst) begin
      n = model_buf.size();
      if (in_valid && n == DEPTH && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 32'd1;
      if (n != 0 && !rf_stall) void'(model_buf.pop_front());
      if (in_valid && n < DEPTH && in_wb_en && in_dest != 5'd0) begin
        e.dest = in_dest;
        e.data = in_mem_r_en ? in_mem_data : in_alu_result;
        model_buf.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on each write.
  always @(negedge clk) begin
    ent_t e;
    check("in_ready", in_ready, model_buf.size() < DEPTH);
    check("wb_write_enable", WB_Write_Enable, model_buf.size() != 0 && !rf_stall);
    check("pending", pending, model_pending());
`ifdef WB_STALL_CNT_EN
    check("stall_cycles_model", stall_cycles, model_stall);
`endif
    if (WB_Write_Enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: dest=%0d data=0x%08h with nothing expected", WB_Dest, WB_Data);
      end else begin
        e = exp_q.pop_front();
        check("wb_dest", WB_Dest, e.dest);
        check("wb_data", WB_Data, e.data);
      end
    end else if (model_buf.size() == 0) begin
      check("idle_dest", WB_Dest, 32'd0);
      check("idle_data", WB_Data, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Holds the offer until it is accepted; in_ready depends only on registered state.
  task automatic send(input logic wb_en, input logic mr, input logic [4:0] d,
                      input logic [31:0] alu, input logic [31:0] mem);
    logic acc;
    int   guard;
    in_valid      = 1'b1;
    in_wb_en      = wb_en;
    in_mem_r_en   = mr;
    in_dest       = d;
    in_alu_result = alu;
    in_mem_data   = mem;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: dest=%0d in_ready=%0b required=1", d, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_buf.delete();
    exp_q.delete();
    model_stall = 32'd0;
    #1;
    check("arst_in_ready", in_ready, 32'd1);
    check("arst_we", WB_Write_Enable, 32'd0);
    check("arst_dest", WB_Dest, 32'd0);
    check("arst_data", WB_Data, 32'd0);
    check("arst_pending", pending, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_wb_en = 1'b0; in_mem_r_en = 1'b0; in_dest = 5'd0;
    in_alu_result = 32'd0; in_mem_data = 32'd0; rf_stall = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_we", WB_Write_Enable, 32'd0);
    check("rst_dest", WB_Dest, 32'd0);
    check("rst_data", WB_Data, 32'd0);
    check("rst_pending", pending, 32'd0);
    rst = 1'b0;

    // single ALU write
    send(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    check("single_pending", pending, 32'h20);
    idle(1);
    check("single_pending_clear", pending, 32'h0);
    idle(2);

    // load select, then an r0 write that must vanish
    send(1'b1, 1'b1, 5'd3, 32'h1111, 32'hDEAD_BEEF);
    send(1'b1, 1'b0, 5'd0, 32'h5555, 32'h0);
    idle(3);

    // fill under stall, hold dest 9 until the port frees
    rf_stall = 1'b1;
    send(1'b1, 1'b0, 5'd7, 32'h70, 32'h0);
    send(1'b1, 1'b0, 5'd8, 32'h80, 32'h0);
    check("full_in_ready", in_ready, 32'd0);
    check("full_pending", pending, 32'h180);
    in_valid = 1'b1; in_dest = 5'd9; in_alu_result = 32'h90;
    repeat (3) step();
    rf_stall = 1'b0;
    send(1'b1, 1'b0, 5'd9, 32'h90, 32'h0);
    idle(4);

    // back-to-back stream through the wrap point
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 5'(10 + i), 32'hA000 + i, 32'h0);
    idle(3);

    // reset with two entries parked behind a stall
    rf_stall = 1'b1;
    send(1'b1, 1'b0, 5'd11, 32'hB1, 32'h0);
    send(1'b1, 1'b0, 5'd12, 32'hB2, 32'h0);
    async_reset();
    rf_stall = 1'b0;
    idle(5);

    // random traffic, small dest range to force duplicates
    for (int i = 0; i < 400; i++) begin
      rf_stall      = ($urandom_range(0, 3) == 0);
      in_valid      = $urandom_range(0, 1) == 1;
      in_wb_en      = ($urandom_range(0, 7) != 0);
      in_mem_r_en   = $urandom_range(0, 1) == 1;
      in_dest       = 5'($urandom_range(0, 7));
      in_alu_result = $urandom;
      in_mem_data   = $urandom;
      step();
    end
    rf_stall = 1'b0;
    idle(4);

`ifdef WB_STALL_CNT_EN
    async_reset();
    rf_stall = 1'b1;
    send(1'b1, 1'b0, 5'd1, 32'h1, 32'h0);
    send(1'b1, 1'b0, 5'd2, 32'h2, 32'h0);
    in_valid = 1'b1; in_dest = 5'd3; in_alu_result = 32'h3;
    repeat (4) step();
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_cycles_4", stall_cycles, 32'd4);
    step();
    rf_stall = 1'b0;
    idle(4);
`endif

    check("drain_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
